valid_beat_counter: RTL and testbench

VALID_BEAT_COUNTER -- requirements
Module: valid_beat_counter

---
 rtl/valid_beat_counter_pkg.sv | 17 +
 rtl/valid_beat_counter.sv | 120 ++++++++++++
 tb/tb_valid_beat_counter.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/valid_beat_counter_pkg.sv
// Shared control constants for valid_beat_counter: FSM state encodings.
// The include guard allows several files to pull this in safely.
`ifndef VALID_BEAT_COUNTER_PKG_SV
`define VALID_BEAT_COUNTER_PKG_SV

package valid_beat_counter_pkg;

  // FSM states of the beat counter; encodings are fixed and shared.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COUNT  = 2'd1,
    ST_FINISH = 2'd2
  } vbc_state_e;

endpackage

`endif

// File: rtl/valid_beat_counter.sv
// valid_beat_counter: counts valid beats on DIN until a latched target is
// reached, then pulses DONE for one cycle. The FSM and counter are inline.
// Optional feature: define VALID_BEAT_COUNTER_ABORT_EN to add the ABORT input,
// which cancels a run in progress without asserting DONE.
`include "valid_beat_counter_pkg.sv"

module valid_beat_counter
  import valid_beat_counter_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               START,
  input  logic [COUNT_W-1:0] TARGET,
  input  logic               DIN,
`ifdef VALID_BEAT_COUNTER_ABORT_EN
  input  logic               ABORT,
`endif
  output logic               BUSY,
  output logic [COUNT_W-1:0] COUNT,
  output logic               DONE
);

  localparam logic [COUNT_W-1:0] CNT_ZERO = {COUNT_W{1'b0}};
  localparam logic [COUNT_W-1:0] CNT_ONE  = COUNT_W'(1);

  vbc_state_e         state_q,  state_d;
  logic [COUNT_W-1:0] count_q,  count_d;
  logic [COUNT_W-1:0] target_q, target_d;
  logic               busy_q,   busy_d;
  logic               done_q,   done_d;
  logic               last_beat_s;

  // The incoming beat is the final one when the count is one short of target.
  always_comb begin
    last_beat_s = (count_q == (target_q - CNT_ONE));
  end

  // Next-state logic: BUSY and DONE are derived from the next state so that
  // they come out of flops aligned with the registered state.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    target_d = target_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // DIN is deliberately not looked at here, even alongside START.
        if (START) begin
          target_d = TARGET;
          count_d  = CNT_ZERO;
          if (TARGET == CNT_ZERO) begin
            state_d = ST_FINISH;
            done_d  = 1'b1;
          end else begin
            state_d = ST_COUNT;
            busy_d  = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COUNT: begin
`ifdef VALID_BEAT_COUNTER_ABORT_EN
        // Abort beats a coincident final beat; the count is frozen.
        if (ABORT) begin
          state_d = ST_IDLE;
        end else
`endif
        if (DIN) begin
          count_d = count_q + CNT_ONE;
          if (last_beat_s) begin
            state_d = ST_FINISH;
            done_d  = 1'b1;
          end else begin
            state_d = ST_COUNT;
            busy_d  = 1'b1;
          end
        end else begin
          state_d = ST_COUNT;
          busy_d  = 1'b1;
        end
      end
      ST_FINISH: begin
        // One-cycle completion state; DIN and START are ignored.
        state_d = ST_IDLE;
      end
      default: begin
        // Unreachable encoding: recover to idle with a cleared run.
        state_d  = ST_IDLE;
        count_d  = CNT_ZERO;
        target_d = CNT_ZERO;
      end
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      count_q  <= CNT_ZERO;
      target_q <= CNT_ZERO;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      target_q <= target_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign BUSY  = busy_q;
  assign COUNT = count_q;
  assign DONE  = done_q;

endmodule

// File: tb/tb_valid_beat_counter.sv
// Directed testbench for valid_beat_counter: a 16-bit instance for the main
// scenarios and a 4-bit instance for the width boundary.
`timescale 1ns/1ps

module tb_valid_beat_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, din, abort;
  logic [15:0] target;
  logic        busy;
  logic [15:0] count;
  logic        done;
  logic        start4, din4;
  logic [3:0]  target4;
  logic        busy4;
  logic [3:0]  count4;
  logic        done4;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  valid_beat_counter #(.COUNT_W(16)) dut (
    .CLK(clk), .RESET(reset), .START(start), .TARGET(target), .DIN(din),
`ifdef VALID_BEAT_COUNTER_ABORT_EN
    .ABORT(abort),
`endif
    .BUSY(busy), .COUNT(count), .DONE(done)
  );

  valid_beat_counter #(.COUNT_W(4)) dut4 (
    .CLK(clk), .RESET(reset), .START(start4), .TARGET(target4), .DIN(din4),
`ifdef VALID_BEAT_COUNTER_ABORT_EN
    .ABORT(1'b0),
`endif
    .BUSY(busy4), .COUNT(count4), .DONE(done4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; din = 1'b1; target = 16'd7;
    tick();
    vectors++;
    if ({busy, done, count} !== {1'b0, 1'b0, 16'd0}) begin
      miscompares++;
      $display("FAIL reset_state: busy=%b done=%b count=%0d, want 0 0 0", busy, done, count);
    end
    vectors++;
    if ({busy4, done4, count4} !== {1'b0, 1'b0, 4'd0}) begin
      miscompares++;
      $display("FAIL reset_state4: busy=%b done=%b count=%0d, want 0 0 0", busy4, done4, count4);
    end
    reset = 1'b0; start = 1'b0; din = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    start = 1'b1; target = 16'd5;
    tick();
    start = 1'b0;
    vectors++;
    if ({busy, done, count} !== {1'b1, 1'b0, 16'd0}) begin
      miscompares++;
      $display("FAIL basic_start: busy=%b done=%b count=%0d, want 1 0 0", busy, done, count);
    end
    for (int i = 1; i <= 5; i++) begin
      din = 1'b1;
      tick();
      din = 1'b0;
      vectors++;
      if ({busy, done, count} !== {(i != 5), (i == 5), 16'(i)}) begin
        miscompares++;
        $display("FAIL basic_beat%0d: busy=%b done=%b count=%0d, want %b %b %0d",
                 i, busy, done, count, (i != 5), (i == 5), i);
      end
      tick();
      vectors++;
      if ({busy, done, count} !== {(i != 5), 1'b0, 16'(i)}) begin
        miscompares++;
        $display("FAIL basic_gap%0d: busy=%b done=%b count=%0d, want %b 0 %0d",
                 i, busy, done, count, (i != 5), i);
      end
    end
    tick(); tick();
    vectors++;
    if ({busy, done, count} !== {1'b0, 1'b0, 16'd5}) begin
      miscompares++;
      $display("FAIL basic_hold: busy=%b done=%b count=%0d, want 0 0 5", busy, done, count);
    end
  endtask

  task automatic test_zero_target();
    start = 1'b1; target = 16'd0;
    tick();
    start = 1'b0;
    vectors++;
    if ({busy, done, count} !== {1'b0, 1'b1, 16'd0}) begin
      miscompares++;
      $display("FAIL zero_done: busy=%b done=%b count=%0d, want 0 1 0", busy, done, count);
    end
    tick();
    vectors++;
    if ({busy, done, count} !== {1'b0, 1'b0, 16'd0}) begin
      miscompares++;
      $display("FAIL zero_after: busy=%b done=%b count=%0d, want 0 0 0", busy, done, count);
    end
  endtask

  task automatic test_ignored_inputs();
    start = 1'b1; din = 1'b1; target = 16'd3;
    tick();
    vectors++;
    if ({busy, done, count} !== {1'b1, 1'b0, 16'd0}) begin
      miscompares++;
      $display("FAIL ign_start_din: busy=%b done=%b count=%0d, want 1 0 0", busy, done, count);
    end
    start = 1'b1; din = 1'b0; target = 16'd9;
    tick();
    start = 1'b0;
    vectors++;
    if ({busy, done, count} !== {1'b1, 1'b0, 16'd0}) begin
      miscompares++;
      $display("FAIL ign_restart: busy=%b done=%b count=%0d, want 1 0 0", busy, done, count);
    end
    din = 1'b1;
    tick(); tick();
    vectors++;
    if ({busy, done, count} !== {1'b1, 1'b0, 16'd2}) begin
      miscompares++;
      $display("FAIL ign_two_beats: busy=%b done=%b count=%0d, want 1 0 2", busy, done, count);
    end
    start = 1'b1; target = 16'd9;
    tick();
    vectors++;
    if ({busy, done, count} !== {1'b0, 1'b1, 16'd3}) begin
      miscompares++;
      $display("FAIL ign_done: busy=%b done=%b count=%0d, want 0 1 3", busy, done, count);
    end
    // START and DIN during FINISH must not restart or advance the count.
    tick();
    start = 1'b0;
    vectors++;
    if ({busy, done, count} !== {1'b0, 1'b0, 16'd3}) begin
      miscompares++;
      $display("FAIL ign_finish: busy=%b done=%b count=%0d, want 0 0 3", busy, done, count);
    end
    tick();
    din = 1'b0;
    vectors++;
    if ({busy, done, count} !== {1'b0, 1'b0, 16'd3}) begin
      miscompares++;
      $display("FAIL ign_idle_din: busy=%b done=%b count=%0d, want 0 0 3", busy, done, count);
    end
  endtask

  task automatic test_reset_midrun();
    start = 1'b1; target = 16'd4;
    tick();
    start = 1'b0; din = 1'b1;
    tick(); tick();
    din = 1'b0;
    vectors++;
    if ({busy, done, count} !== {1'b1, 1'b0, 16'd2}) begin
      miscompares++;
      $display("FAIL mid_pre: busy=%b done=%b count=%0d, want 1 0 2", busy, done, count);
    end
    reset = 1'b1; din = 1'b1;
    tick();
    reset = 1'b0; din = 1'b0;
    vectors++;
    if ({busy, done, count} !== {1'b0, 1'b0, 16'd0}) begin
      miscompares++;
      $display("FAIL mid_reset: busy=%b done=%b count=%0d, want 0 0 0", busy, done, count);
    end
    tick();
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_no_done: done=%b, want 0", done);
    end
    start = 1'b1; target = 16'd1;
    tick();
    start = 1'b0; din = 1'b1;
    tick();
    din = 1'b0;
    vectors++;
    if ({busy, done, count} !== {1'b0, 1'b1, 16'd1}) begin
      miscompares++;
      $display("FAIL mid_rerun: busy=%b done=%b count=%0d, want 0 1 1", busy, done, count);
    end
    tick();
  endtask

  task automatic test_width_boundary();
    start4 = 1'b1; target4 = 4'd15;
    tick();
    start4 = 1'b0; din4 = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      vectors++;
      if ({busy4, done4, count4} !== {(i != 15), (i == 15), 4'(i)}) begin
        miscompares++;
        $display("FAIL width_beat%0d: busy=%b done=%b count=%0d, want %b %b %0d",
                 i, busy4, done4, count4, (i != 15), (i == 15), i);
      end
    end
    tick();
    din4 = 1'b0;
    vectors++;
    if ({busy4, done4, count4} !== {1'b0, 1'b0, 4'd15}) begin
      miscompares++;
      $display("FAIL width_nowrap: busy=%b done=%b count=%0d, want 0 0 15", busy4, done4, count4);
    end
  endtask

`ifdef VALID_BEAT_COUNTER_ABORT_EN
  task automatic test_abort();
    abort = 1'b1; start = 1'b1; target = 16'd3;
    tick();
    abort = 1'b0; start = 1'b0; din = 1'b1;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_idle_ignored: busy=%b, want 1", busy);
    end
    tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0; din = 1'b0;
    vectors++;
    if ({busy, done, count} !== {1'b0, 1'b0, 16'd2}) begin
      miscompares++;
      $display("FAIL abort_final: busy=%b done=%b count=%0d, want 0 0 2", busy, done, count);
    end
    tick();
    vectors++;
    if ({busy, done, count} !== {1'b0, 1'b0, 16'd2}) begin
      miscompares++;
      $display("FAIL abort_after: busy=%b done=%b count=%0d, want 0 0 2", busy, done, count);
    end
  endtask
`endif

  initial begin
    reset = 1'b1; start = 1'b0; din = 1'b0; abort = 1'b0; target = 16'd0;
    start4 = 1'b0; din4 = 1'b0; target4 = 4'd0;
    tick();
    test_reset();
    test_basic();
    test_zero_target();
    test_ignored_inputs();
    test_reset_midrun();
    test_width_boundary();
`ifdef VALID_BEAT_COUNTER_ABORT_EN
    test_abort();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
